// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine: counts 5-bit pattern matches (within-byte, per-byte, whole-string) in a memory-resident bit string
module pattern_scan_engine #(
  parameter int NUM_BYTES = 32,
  parameter int BASE_ADDR = 0,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_wr_en,
  output logic [7:0]    mem_wr_data
);
  localparam int IW = $clog2(NUM_BYTES + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_LDPAT = 3'd1, S_SCAN = 3'd2, S_WR0 = 3'd3,
                         S_WR1 = 3'd4, S_WR2 = 3'd5, S_DONE = 3'd6;
  logic [2:0] state_q, state_d;
  logic [4:0] pat_q, pat_d;
  logic [7:0] prev_q, prev_d, ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [11:0] w;
  logic [2:0] m, x;
  logic [3:0] s;
  function automatic logic [7:0] sat(input logic [7:0] a, input logic [3:0] b);
    logic [8:0] t;
    t = {1'b0, a} + {5'b0, b};
    return t[8] ? 8'hFF : t[7:0];
  endfunction
  // k=0..3 of w lie inside the current byte, k=4..7 straddle into the previous one
  always_comb begin
    w = {prev_q[3:0], mem_rd_data};
    m = '0;
    x = '0;
    for (int k = 0; k < 4; k++) m = m + 3'(w[k+:5] == pat_q);
    for (int k = 4; k < 8; k++) x = x + 3'(w[k+:5] == pat_q);
    s = (idx_q == '0) ? {1'b0, m} : {1'b0, m} + {1'b0, x};
  end
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    prev_d = prev_q;
    ctb_d = ctb_q;
    cto_d = cto_q;
    cts_d = cts_q;
    idx_d = idx_q;
    case (state_q)
      S_IDLE, S_DONE: state_d = start ? S_LDPAT : state_q;
      S_LDPAT: begin
        pat_d = mem_rd_data[7:3];
        {prev_d, ctb_d, cto_d, cts_d, idx_d} = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        ctb_d = sat(ctb_q, {1'b0, m});
        cto_d = sat(cto_q, {3'b0, m != '0});
        cts_d = sat(cts_q, s);
        prev_d = mem_rd_data;
        idx_d = idx_q + 1'b1;
        state_d = (idx_q == IW'(NUM_BYTES - 1)) ? S_WR0 : S_SCAN;
      end
      S_WR0: state_d = S_WR1;
      S_WR1: state_d = S_WR2;
      S_WR2: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      {pat_q, prev_q, ctb_q, cto_q, cts_q, idx_q} <= '0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      prev_q <= prev_d;
      ctb_q <= ctb_d;
      cto_q <= cto_d;
      cts_q <= cts_d;
      idx_q <= idx_d;
    end
  end
  always_comb begin
    done = state_q == S_DONE;
    mem_wr_en = state_q == S_WR0 || state_q == S_WR1 || state_q == S_WR2;
    mem_addr = state_q == S_LDPAT ? AW'(PAT_ADDR) :
               state_q == S_SCAN  ? AW'(BASE_ADDR) + AW'(idx_q) :
               state_q == S_WR0   ? AW'(RES_ADDR) :
               state_q == S_WR1   ? AW'(RES_ADDR + 1) :
               state_q == S_WR2   ? AW'(RES_ADDR + 2) : '0;
    mem_wr_data = state_q == S_WR0 ? ctb_q :
                  state_q == S_WR1 ? cto_q :
                  state_q == S_WR2 ? cts_q : 8'h00;
  end
endmodule

// File: tb/tb_pattern_scan_engine.sv
// tb_pattern_scan_engine: scoreboard bench comparing result writes against a bit-string window-count model
module tb_pattern_scan_engine;
  localparam int NB = 32, PA = 32, RA = 33;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic done, mem_wr_en;
  logic [7:0] mem_addr, mem_rd_data, mem_wr_data;
  logic [7:0] dm_in [256];
  logic [7:0] res [256];
  logic [15:0] exp_q [$];
  logic [15:0] e_w;
  int vecs = 0, errs = 0, wr_cnt = 0;
  always #5 clk = ~clk;
  assign mem_rd_data = dm_in[mem_addr];
  pattern_scan_engine dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(posedge clk) if (mem_wr_en) res[mem_addr] <= mem_wr_data;
  always @(negedge clk) if (mem_wr_en) begin
    wr_cnt++;
    if (exp_q.size() == 0) chk("unexpected_write", int'(mem_addr), -1);
    else begin
      e_w = exp_q.pop_front();
      chk("wr_addr", int'(mem_addr), int'(e_w[15:8]));
      chk("wr_data", int'(mem_wr_data), int'(e_w[7:0]));
    end
  end
  // Every 5-bit window of the MSB-first string counts toward cts; windows inside one byte also toward ctb/cto
  task automatic model(input logic [4:0] p, output int ctb, output int cto, output int cts);
    bit s [NB*8];
    bit hit [NB];
    logic [4:0] v;
    ctb = 0; cto = 0; cts = 0;
    for (int j = 0; j < NB*8; j++) s[j] = dm_in[j/8][7 - j%8];
    for (int i = 0; i < NB; i++) hit[i] = 0;
    for (int j = 0; j + 5 <= NB*8; j++) begin
      v = {s[j], s[j+1], s[j+2], s[j+3], s[j+4]};
      if (v == p) begin
        cts++;
        if (j/8 == (j+4)/8) begin ctb++; hit[j/8] = 1; end
      end
    end
    for (int i = 0; i < NB; i++) cto += int'(hit[i]);
    if (ctb > 255) ctb = 255;
    if (cts > 255) cts = 255;
  endtask
  task automatic fill(input logic [7:0] v0, input logic [7:0] v1);
    for (int i = 0; i < NB; i++) dm_in[i] = (i % 2 == 1) ? v1 : v0;
  endtask
  task automatic run(input logic [4:0] p, input bit noise, input string nm);
    int a, b, c, n, w0;
    dm_in[PA] = {p, 3'($urandom)};
    model(p, a, b, c);
    exp_q.push_back({8'(RA), 8'(a)});
    exp_q.push_back({8'(RA+1), 8'(b)});
    exp_q.push_back({8'(RA+2), 8'(c)});
    w0 = wr_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    chk({nm, "_done_low"}, int'(done), 0);
    while (!done && n < 100) begin
      start = noise && n == 10;
      @(posedge clk);
      #1 start = 1'b0;
      n++;
    end
    chk({nm, "_latency"}, n, NB + 5);
    chk({nm, "_writes"}, wr_cnt - w0, 3);
    chk({nm, "_dm_ctb"}, int'(res[RA]), a);
    chk({nm, "_dm_cto"}, int'(res[RA+1]), b);
    chk({nm, "_dm_cts"}, int'(res[RA+2]), c);
    chk({nm, "_queue"}, exp_q.size(), 0);
  endtask
  initial begin
    int w0;
    logic [7:0] sel [4];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", int'(done), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_wr_data", int'(mem_wr_data), 0);
    reset = 1'b0;
    fill(8'h00, 8'h00); run(5'b00000, 0, "zero");
    fill(8'hFF, 8'hFF); run(5'b11111, 0, "ones");
    fill(8'h00, 8'h00); run(5'b11111, 0, "none");
    fill(8'h55, 8'h55); run(5'b10101, 1, "alt55");
    fill(8'h07, 8'hC0); run(5'b11111, 0, "cross");
    // reset during SCAN byte 10 must abandon the scan with no writes
    for (int i = 0; i < NB; i++) dm_in[i] = 8'($urandom);
    w0 = wr_cnt;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("midrst_done", int'(done), 0);
    chk("midrst_addr", int'(mem_addr), 0);
    repeat (50) @(posedge clk);
    #1;
    chk("midrst_writes", wr_cnt - w0, 0);
    chk("midrst_idle", int'(done), 0);
    run(5'($urandom), 0, "after_rst");
    // reset and start together: reset wins
    #1 reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    chk("rst_start_addr", int'(mem_addr), 0);
    w0 = wr_cnt;
    repeat (45) @(posedge clk);
    #1;
    chk("rst_start_writes", wr_cnt - w0, 0);
    chk("rst_start_done", int'(done), 0);
    for (int r = 0; r < 200; r++) begin
      logic [4:0] p;
      p = 5'($urandom);
      sel[0] = 8'h00; sel[1] = 8'hFF; sel[2] = {p, p[4:2]}; sel[3] = {p[2:0], p};
      for (int i = 0; i < NB; i++)
        dm_in[i] = (r % 2 == 0) ? 8'($urandom) : sel[$urandom_range(0, 3)];
      run(p, 1'($urandom), "rand");
    end
    chk("final_queue", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
